// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder that time-shares one 4-bit carry-lookahead slice,
// one nibble per cycle, with valid/ready handshakes on both sides.
module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
  assign s = w_p ^ w_c[3:0];
  assign co = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co
);
  localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [4*NIBBLES-1:0] r_a, r_b;
  logic r_c;
  logic [KW-1:0] r_k;
  logic [3:0] w_s;
  logic w_co;
  nibble_cla4 u_cla (
    .a  (r_a[{r_k, 2'b00} +: 4]),
    .b  (r_b[{r_k, 2'b00} +: 4]),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_c       <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a      <= a;
          r_b      <= b;
          r_c      <= ci;
          r_k      <= '0;
          r_state  <= RUN;
          in_ready <= 1'b0;
        end
        RUN: begin
          s[{r_k, 2'b00} +: 4] <= w_s;
          r_c <= w_co;
          r_k <= r_k + KW'(1);
          if (r_k == KW'(NIBBLES - 1)) begin
            co        <= w_co;
            r_state   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the nibble-serial adder.
module tb_nibble_serial_adder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, ci = 0;
  logic in_ready, out_valid, co;
  logic [15:0] a = 0, b = 0, s;
  int ntest = 0, nfail = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input logic xc);
    @(negedge clk);
    a = xa; b = xb; ci = xc; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake;
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    ntest++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    ntest++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    ntest++; if ({co, s} !== 17'h0) begin nfail++; $display("FAIL reset_sum got %h want 0", {co, s}); end
  endtask

  task automatic test_basic;
    int n;
    issue(16'h1234, 16'h4321, 0);
    wait_done(n);
    ntest++; if (n != 4) begin nfail++; $display("FAIL basic_latency got %0d want 4", n); end
    ntest++; if ({co, s} !== 17'h05555) begin nfail++; $display("FAIL basic_sum got %h want 05555", {co, s}); end
    handshake();
    ntest++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ripple;
    int n;
    issue(16'hFFFF, 16'h0001, 0);
    wait_done(n);
    ntest++; if (n != 4 || {co, s} !== 17'h10000) begin nfail++; $display("FAIL ripple_b got %h lat %0d want 10000 lat 4", {co, s}, n); end
    handshake();
    issue(16'hFFFF, 16'h0000, 1);
    wait_done(n);
    ntest++; if (n != 4 || {co, s} !== 17'h10000) begin nfail++; $display("FAIL ripple_ci got %h lat %0d want 10000 lat 4", {co, s}, n); end
    handshake();
  endtask

  task automatic test_backpressure;
    int n;
    issue(16'h8000, 16'h8000, 0);
    wait_done(n);
    ntest++; if (n != 4 || {co, s} !== 17'h10000) begin nfail++; $display("FAIL bp_sum got %h lat %0d want 10000 lat 4", {co, s}, n); end
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      out_ready = 0;
      @(negedge clk);
      ntest++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {co, s} !== 17'h10000) begin
        nfail++; $display("FAIL bp_hold got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=10000", out_valid, in_ready, {co, s});
      end
    end
    handshake();
    ntest++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nfail++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run;
    int n;
    issue(16'hAAAA, 16'h5555, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ntest++; if ({co, s} !== 17'h0 || in_ready !== 1'b1) begin nfail++; $display("FAIL abort_state got sum=%h ir=%b want sum=0 ir=1", {co, s}, in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ntest++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL abort_no_valid got %b want 0", out_valid); end
    end
    issue(16'h0F0F, 16'h00F1, 0);
    wait_done(n);
    ntest++; if (n != 4 || {co, s} !== 17'h01000) begin nfail++; $display("FAIL abort_next got %h lat %0d want 01000 lat 4", {co, s}, n); end
    handshake();
  endtask

  task automatic test_isolation;
    int n;
    issue(16'h7FFF, 16'h0001, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
    end
    ntest++; if (n != 4 || {co, s} !== 17'h08000) begin nfail++; $display("FAIL isolation got %h lat %0d want 08000 lat 4", {co, s}, n); end
    handshake();
  endtask

  task automatic test_random;
    int n;
    logic [15:0] xa, xb;
    logic xc;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
      exp = {1'b0, xa} + {1'b0, xb} + {16'b0, xc};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(xa, xb, xc);
      wait_done(n);
      ntest++; if (n != 4) begin nfail++; $display("FAIL rand_latency op %0d got %0d want 4", i, n); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ntest++; if ({co, s} !== exp) begin nfail++; $display("FAIL rand_sum op %0d got %h want %h", i, {co, s}, exp); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_isolation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
